// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: request/response payloads,
// FSM state encoding and bus widths.
package dmem_responder_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } dmem_req_t;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_ACCESS,
    DMEM_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the MEM stage (master)
// and the data memory responder (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [BE_W-1:0] req_be;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_sram_array.sv
// Single-port word array: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_sram_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [BE_W-1:0] be_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, performs the array access and holds the response until consumed.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  dmem_state_e     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  dmem_req_t       req_q, req_d;
  dmem_rsp_t       rsp_q, rsp_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic [XLEN-1:0] offset;
  logic            fault;
  logic            mem_we;
  logic [XLEN-1:0] mem_rdata;

  // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign offset = req_q.addr - BASE_ADDR;
  assign fault  = ({1'b0, offset} >= LIMIT) || (req_q.be == '0);

  dmem_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (offset[AW+1:2]),
    .wdata_i (req_q.wdata),
    .be_i    (req_q.be),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rsp_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          req_d.we    = bus.req_we;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          req_d.be    = bus.req_be;
          if (LAT != 4'd0) begin
            state_d = DMEM_WAIT;
            cnt_d   = LAT;
          end else begin
            state_d = DMEM_ACCESS;
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DMEM_ACCESS;
        end
      end
      DMEM_ACCESS: begin
        state_d = DMEM_RESP;
      end
      DMEM_RESP: begin
        if (bus.rsp_ready) begin
          state_d = DMEM_IDLE;
        end
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_comb begin
    mem_we      = 1'b0;
    rsp_d       = rsp_q;
    req_ready_d = (state_d == DMEM_IDLE);
    rsp_valid_d = (state_d == DMEM_RESP);
    if (state_q == DMEM_ACCESS) begin
      mem_we      = req_q.we && !fault;
      rsp_d.err   = fault;
      rsp_d.rdata = (!fault && !req_q.we) ? mem_rdata : '0;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one DUT at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .BASE_ADDR(32'h0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  function automatic logic req_rdy(input bit f);
    return f ? bus0.req_ready : bus.req_ready;
  endfunction

  function automatic logic rsp_vld(input bit f);
    return f ? bus0.rsp_valid : bus.rsp_valid;
  endfunction

  function automatic logic [31:0] rsp_data(input bit f);
    return f ? bus0.rsp_rdata : bus.rsp_rdata;
  endfunction

  function automatic logic rsp_error(input bit f);
    return f ? bus0.rsp_err : bus.rsp_err;
  endfunction

  task automatic drive_req(input bit f, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    if (f) begin
      bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
      bus0.req_wdata = wdata; bus0.req_be = be;
    end else begin
      bus.req_valid = v; bus.req_we = we; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_be = be;
    end
  endtask

  // lat counts cycles from acceptance to the first cycle rsp_valid is seen.
  task automatic txn(input bit f, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output logic [31:0] rdata, output logic err, output int lat);
    bit ok;
    rdata = '0; err = 1'b0; lat = -1;
    @(negedge clk);
    drive_req(f, 1'b1, we, addr, wdata, be);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (req_rdy(f)) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL accept_timeout addr=%h: req_ready never rose", addr);
      drive_req(f, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk); #1;
    drive_req(f, 1'b0, 1'b0, '0, '0, '0);
    ok = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_vld(f)) begin
        ok = 1'b1; lat = n; rdata = rsp_data(f); err = rsp_error(f);
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL rsp_timeout addr=%h: rsp_valid never rose", addr);
      return;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.rsp_ready = 1'b1; bus0.rsp_ready = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
    checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus.rsp_err); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus0.req_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_release_ready got=%b/%b exp=1/1", bus.req_ready, bus0.req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL store_latency got=%0d exp=4", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL store_err got=%b exp=0", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL store_rdata got=%h exp=0", rd); end
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL load_rdata got=%h exp=deadbeef", rd); end
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL load_err got=%b exp=0", er); end
    checks++; if (lat != 4) begin failures++; $display("[TB] FAIL load_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
    txn(1'b0, 1'b1, 32'h20, 32'h00AA0000, 4'b0100, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL partial_store_err got=%b exp=0", er); end
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h11AA3344) begin failures++; $display("[TB] FAIL partial_load got=%h exp=11aa3344", rd); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b0) begin failures++; $display("[TB] FAIL last_word_store_err got=%b exp=0", er); end
    txn(1'b0, 1'b0, 32'h1000, 32'h0, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL oob_load_err got=%b exp=1", er); end
    checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL oob_load_rdata got=%h exp=0", rd); end
    txn(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1) begin failures++; $display("[TB] FAIL oob_store_err got=%b exp=1", er); end
    txn(1'b0, 1'b0, 32'hFFC, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      failures++; $display("[TB] FAIL last_word_reread got=%h/%b exp=cafef00d/0", rd, er);
    end
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL zero_be got=%h/%b exp=00000000/1", rd, er);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 1'b0, 32'h10, '0, 4'hF);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    if (ok) begin
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.rsp_valid) begin ok = 1'b1; break; end
      end
    end
    checks++; if (!ok) begin failures++; $display("[TB] FAIL bp_response got=none exp=rsp_valid"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF ||
          bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_hold cycle=%0d got v=%b d=%h e=%b r=%b exp v=1 d=deadbeef e=0 r=0",
                 i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL bp_release got r=%b v=%b exp r=1 v=0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic er; int lat;
    int stamps[$];
    bit data_ok;
    txn(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 4'hF, rd, er, lat);
    checks++; if (lat != 2) begin failures++; $display("[TB] FAIL lat0_store_latency got=%0d exp=2", lat); end
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    checks++; if (lat != 2 || rd !== 32'hA5A5A5A5) begin
      failures++; $display("[TB] FAIL lat0_load got lat=%0d d=%h exp lat=2 d=a5a5a5a5", lat, rd);
    end
    @(negedge clk);
    drive_req(1'b1, 1'b1, 1'b0, 32'h8, '0, 4'hF);
    data_ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid) begin
        stamps.push_back(cyc);
        if (bus0.rsp_rdata !== 32'hA5A5A5A5) data_ok = 1'b0;
      end
    end
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) @(negedge clk);
    checks++; if (stamps.size() < 4) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp>=4", stamps.size()); end
    checks++; if (!data_ok) begin failures++; $display("[TB] FAIL b2b_rdata got=wrong exp=a5a5a5a5"); end
    for (int i = 1; i < stamps.size(); i++) begin
      checks++;
      if (stamps[i] - stamps[i-1] != 3) begin
        failures++; $display("[TB] FAIL b2b_spacing idx=%0d got=%0d exp=3", i, stamps[i] - stamps[i-1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    bit saw_valid;
    txn(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, rd, er, lat);
    @(negedge clk);
    drive_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h00000055, 4'hF);
    for (int n = 0; n < 20; n++) begin
      if (bus.req_ready) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_ready got=%b exp=0", bus.req_ready); end
      if (bus.rsp_valid !== 1'b0) saw_valid = 1'b1;
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++; if (saw_valid) begin failures++; $display("[TB] FAIL mid_reset_rsp got=rsp_valid high exp=never"); end
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_reset_release got=%b exp=1", bus.req_ready); end
    txn(1'b0, 1'b0, 32'h40, 32'h0, 4'hF, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin failures++; $display("[TB] FAIL mid_reset_load got=%h exp=12345678", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_partial_store();
    test_faults();
    test_backpressure();
    test_latency0();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
